// File: rtl/series_accumulator_if.sv
// Request/result bus of the series accumulator.
//   master : drives start, abort, mode, n_lo, n_hi; observes busy, done, sum, overflow
//   slave  : the accumulator side of the same bus
interface series_accumulator_if #(
   parameter int unsigned N_W   = 8,
   parameter int unsigned SUM_W = 24
);
   logic             start;
   logic             abort;
   logic             mode;
   logic [N_W-1:0]   n_lo;
   logic [N_W-1:0]   n_hi;
   logic             busy;
   logic             done;
   logic [SUM_W-1:0] sum;
   logic             overflow;

   modport master (
      output start, abort, mode, n_lo, n_hi,
      input  busy, done, sum, overflow
   );

   modport slave (
      input  start, abort, mode, n_lo, n_hi,
      output busy, done, sum, overflow
   );
endinterface

// File: rtl/series_accumulator.sv
// Sequential series engine: sums term(i) for i = n_lo..n_hi, one term per clock.
// mode 0 sums i, mode 1 sums i*i. Start/busy/done handshake, abort, empty-range
// handling and a sticky overflow flag for the completed result.
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      slave side of series_accumulator_if (start/abort/mode/n_lo/n_hi in,
//            busy/done/sum/overflow out, all outputs registered)
module series_accumulator #(
   parameter int unsigned N_W   = 8,
   parameter int unsigned SUM_W = 24
) (
   input  logic               clock,
   input  logic               reset_n,
   series_accumulator_if.slave bus
);

   localparam int unsigned SQ_W  = 2 * N_W;
   // Adder is wide enough to expose both the carry and any excess term bits.
   localparam int unsigned EXT_W = (SQ_W > SUM_W) ? SQ_W + 1 : SUM_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic             mode_q, mode_nxt;
   logic [N_W-1:0]   hi_q, hi_nxt;
   logic [N_W-1:0]   idx, idx_nxt;
   logic [SUM_W-1:0] acc, acc_nxt;
   logic             ovf_acc, ovf_acc_nxt;
   logic             busy_nxt, done_nxt, ovf_nxt;
   logic [SUM_W-1:0] sum_nxt;

   logic [SQ_W-1:0]  square;
   logic [EXT_W-1:0] term;
   logic [EXT_W-1:0] total;

   // Term and widened partial sum for the current index.
   always_comb begin
      square = SQ_W'(idx) * SQ_W'(idx);
      term   = mode_q ? EXT_W'(square) : EXT_W'(idx);
      total  = EXT_W'(acc) + term;
   end

   // Next-state and next-register logic.
   always_comb begin
      state_nxt   = state;
      mode_nxt    = mode_q;
      hi_nxt      = hi_q;
      idx_nxt     = idx;
      acc_nxt     = acc;
      ovf_acc_nxt = ovf_acc;

      case (state)
         IDLE: begin
            if (bus.start) begin
               acc_nxt     = '0;
               ovf_acc_nxt = 1'b0;
               if (bus.n_lo <= bus.n_hi) begin
                  mode_nxt  = bus.mode;
                  hi_nxt    = bus.n_hi;
                  idx_nxt   = bus.n_lo;
                  state_nxt = ACCUM;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         ACCUM: begin
            if (bus.abort) begin
               state_nxt = IDLE;
            end else begin
               acc_nxt     = total[SUM_W-1:0];
               ovf_acc_nxt = ovf_acc | (|total[EXT_W-1:SUM_W]);
               // Compare before increment so idx never wraps at the top of range.
               if (idx == hi_q) begin
                  state_nxt = DONE;
               end else begin
                  idx_nxt = idx + N_W'(1);
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Outputs are registered from the next state so they align with it;
      // the result is published together with the done pulse.
      busy_nxt = (state_nxt != IDLE);
      done_nxt = (state_nxt == DONE);
      sum_nxt  = done_nxt ? acc_nxt : bus.sum;
      ovf_nxt  = done_nxt ? ovf_acc_nxt : bus.overflow;
   end

   // State and datapath registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         mode_q       <= 1'b0;
         hi_q         <= '0;
         idx          <= '0;
         acc          <= '0;
         ovf_acc      <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.sum      <= '0;
         bus.overflow <= 1'b0;
      end else begin
         state        <= state_nxt;
         mode_q       <= mode_nxt;
         hi_q         <= hi_nxt;
         idx          <= idx_nxt;
         acc          <= acc_nxt;
         ovf_acc      <= ovf_acc_nxt;
         bus.busy     <= busy_nxt;
         bus.done     <= done_nxt;
         bus.sum      <= sum_nxt;
         bus.overflow <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_series_accumulator.sv
// Directed bench for series_accumulator: a 24-bit-sum instance (a) and an
// 8-bit-sum instance (b) sharing clock and reset.
module tb_series_accumulator;

   logic clock;
   logic reset_n;
   int   tests_run;
   int   tests_failed;

   series_accumulator_if #(.N_W(8), .SUM_W(24)) a ();
   series_accumulator_if #(.N_W(8), .SUM_W(8))  b ();

   series_accumulator #(.N_W(8), .SUM_W(24)) dut_a (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (a.slave)
   );

   series_accumulator #(.N_W(8), .SUM_W(8)) dut_b (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (b.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Issue a start in cycle 0 and return the cycle in which done was seen.
   task automatic run_a(input logic m, input logic [7:0] lo, input logic [7:0] hi,
                        output int cyc);
      a.mode = m; a.n_lo = lo; a.n_hi = hi; a.start = 1'b1;
      tick;
      a.start = 1'b0;
      cyc = 1;
      while (a.done !== 1'b1 && cyc < 600) begin
         tick;
         cyc++;
      end
   endtask

   task automatic run_b(input logic m, input logic [7:0] lo, input logic [7:0] hi,
                        output int cyc);
      b.mode = m; b.n_lo = lo; b.n_hi = hi; b.start = 1'b1;
      tick;
      b.start = 1'b0;
      cyc = 1;
      while (b.done !== 1'b1 && cyc < 600) begin
         tick;
         cyc++;
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      tests_run++;
      if ({a.busy, a.done, a.overflow} !== 3'b000) begin
         tests_failed++; $display("FAIL reset_flags_a: got %b expected 000", {a.busy, a.done, a.overflow});
      end
      tests_run++;
      if (a.sum !== 24'd0) begin
         tests_failed++; $display("FAIL reset_sum_a: got %0d expected 0", a.sum);
      end
      tests_run++;
      if ({b.busy, b.done, b.overflow, b.sum} !== 11'd0) begin
         tests_failed++; $display("FAIL reset_b: got %h expected 0", {b.busy, b.done, b.overflow, b.sum});
      end
      tick; tick;
      @(negedge clock);
      reset_n = 1'b1;
      tick;
   endtask

   task automatic test_sum_i;
      int cyc;
      int busy_cnt;
      a.mode = 1'b0; a.n_lo = 8'd1; a.n_hi = 8'd4; a.start = 1'b1;
      tick;
      a.start = 1'b0;
      cyc = 1;
      busy_cnt = 0;
      while (a.done !== 1'b1 && cyc < 50) begin
         if (a.busy === 1'b1) busy_cnt++;
         tick;
         cyc++;
      end
      if (a.busy === 1'b1) busy_cnt++;
      tests_run++;
      if (cyc !== 5) begin
         tests_failed++; $display("FAIL sum_i_latency: got %0d expected 5", cyc);
      end
      tests_run++;
      if (busy_cnt !== 5) begin
         tests_failed++; $display("FAIL sum_i_busy_cycles: got %0d expected 5", busy_cnt);
      end
      tests_run++;
      if ({a.overflow, a.sum} !== {1'b0, 24'd10}) begin
         tests_failed++; $display("FAIL sum_i_result: got ovf=%b sum=%0d expected ovf=0 sum=10", a.overflow, a.sum);
      end
      tick;
      tests_run++;
      if ({a.busy, a.done} !== 2'b00) begin
         tests_failed++; $display("FAIL sum_i_after: got busy/done=%b expected 00", {a.busy, a.done});
      end
   endtask

   task automatic test_sum_sq;
      int cyc;
      run_a(1'b1, 8'd1, 8'd4, cyc);
      tests_run++;
      if (cyc !== 5 || a.sum !== 24'd30) begin
         tests_failed++; $display("FAIL sum_sq_small: got cyc=%0d sum=%0d expected cyc=5 sum=30", cyc, a.sum);
      end
      tick;
      run_a(1'b1, 8'd1, 8'd255, cyc);
      tests_run++;
      if (cyc !== 256 || a.sum !== 24'd5559680 || a.overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL sum_sq_full: got cyc=%0d sum=%0d ovf=%b expected cyc=256 sum=5559680 ovf=0",
                  cyc, a.sum, a.overflow);
      end
      tick;
   endtask

   task automatic test_empty_single;
      int cyc;
      run_a(1'b0, 8'd5, 8'd3, cyc);
      tests_run++;
      if (cyc !== 1 || a.sum !== 24'd0 || a.overflow !== 1'b0) begin
         tests_failed++; $display("FAIL empty_range: got cyc=%0d sum=%0d expected cyc=1 sum=0", cyc, a.sum);
      end
      tick;
      run_a(1'b1, 8'd7, 8'd7, cyc);
      tests_run++;
      if (cyc !== 2 || a.sum !== 24'd49) begin
         tests_failed++; $display("FAIL single_term: got cyc=%0d sum=%0d expected cyc=2 sum=49", cyc, a.sum);
      end
      tick;
   endtask

   task automatic test_overflow;
      int cyc;
      run_b(1'b0, 8'd1, 8'd30, cyc);
      tests_run++;
      if (cyc !== 31 || b.sum !== 8'd209 || b.overflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovf_carry: got cyc=%0d sum=%0d ovf=%b expected cyc=31 sum=209 ovf=1", cyc, b.sum, b.overflow);
      end
      tick;
      run_b(1'b1, 8'd16, 8'd16, cyc);
      tests_run++;
      if (b.sum !== 8'd0 || b.overflow !== 1'b1) begin
         tests_failed++; $display("FAIL ovf_wide_term: got sum=%0d ovf=%b expected sum=0 ovf=1", b.sum, b.overflow);
      end
      tick;
      run_b(1'b0, 8'd1, 8'd20, cyc);
      tests_run++;
      if (b.sum !== 8'd210 || b.overflow !== 1'b0) begin
         tests_failed++; $display("FAIL ovf_cleared: got sum=%0d ovf=%b expected sum=210 ovf=0", b.sum, b.overflow);
      end
      tick;
   endtask

   task automatic test_abort;
      int seen_done;
      a.mode = 1'b0; a.n_lo = 8'd1; a.n_hi = 8'd10; a.start = 1'b1;
      tick;
      a.start = 1'b0;
      tick;
      tick;
      a.abort = 1'b1;
      tick;
      a.abort = 1'b0;
      tests_run++;
      if ({a.busy, a.done} !== 2'b00) begin
         tests_failed++; $display("FAIL abort_idle: got busy/done=%b expected 00", {a.busy, a.done});
      end
      seen_done = 0;
      for (int i = 0; i < 15; i++) begin
         if (a.done === 1'b1) seen_done++;
         tick;
      end
      tests_run++;
      if (seen_done !== 0 || a.sum !== 24'd49) begin
         tests_failed++; $display("FAIL abort_no_done: got done_pulses=%0d sum=%0d expected 0 and 49", seen_done, a.sum);
      end
   endtask

   task automatic test_start_ignored;
      int cyc;
      a.mode = 1'b0; a.n_lo = 8'd1; a.n_hi = 8'd10; a.start = 1'b1;
      tick;
      a.mode = 1'b1; a.n_lo = 8'd2; a.n_hi = 8'd3;
      tick;
      tick;
      a.start = 1'b0;
      cyc = 3;
      while (a.done !== 1'b1 && cyc < 50) begin
         tick;
         cyc++;
      end
      tests_run++;
      if (cyc !== 11 || a.sum !== 24'd55) begin
         tests_failed++; $display("FAIL start_while_busy: got cyc=%0d sum=%0d expected cyc=11 sum=55", cyc, a.sum);
      end
      tick;
   endtask

   task automatic test_back_to_back;
      int cyc;
      run_a(1'b0, 8'd1, 8'd4, cyc);
      // start during DONE must be ignored
      a.mode = 1'b0; a.n_lo = 8'd1; a.n_hi = 8'd9; a.start = 1'b1;
      tick;
      a.start = 1'b0;
      tests_run++;
      if (a.busy !== 1'b0 || a.sum !== 24'd10) begin
         tests_failed++; $display("FAIL start_in_done: got busy=%b sum=%0d expected busy=0 sum=10", a.busy, a.sum);
      end
      run_a(1'b1, 8'd2, 8'd3, cyc);
      tests_run++;
      if (cyc !== 3 || a.sum !== 24'd13) begin
         tests_failed++; $display("FAIL back_to_back: got cyc=%0d sum=%0d expected cyc=3 sum=13", cyc, a.sum);
      end
      tick;
   endtask

   task automatic test_reset_mid;
      int cyc;
      a.mode = 1'b0; a.n_lo = 8'd1; a.n_hi = 8'd10; a.start = 1'b1;
      tick;
      a.start = 1'b0;
      tick;
      tick;
      #3 reset_n = 1'b0;
      #1;
      tests_run++;
      if ({a.busy, a.done, a.overflow} !== 3'b000 || a.sum !== 24'd0) begin
         tests_failed++;
         $display("FAIL reset_mid_a: got busy=%b done=%b ovf=%b sum=%0d expected all 0", a.busy, a.done, a.overflow, a.sum);
      end
      tests_run++;
      if (b.sum !== 8'd0) begin
         tests_failed++; $display("FAIL reset_mid_b: got sum=%0d expected 0", b.sum);
      end
      #2 reset_n = 1'b1;
      tick;
      run_a(1'b0, 8'd3, 8'd5, cyc);
      tests_run++;
      if (cyc !== 4 || a.sum !== 24'd12) begin
         tests_failed++; $display("FAIL after_reset_run: got cyc=%0d sum=%0d expected cyc=4 sum=12", cyc, a.sum);
      end
      tick;
      run_a(1'b0, 8'd0, 8'd255, cyc);
      tests_run++;
      if (cyc !== 257 || a.sum !== 24'd32640 || a.overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_range: got cyc=%0d sum=%0d ovf=%b expected cyc=257 sum=32640 ovf=0", cyc, a.sum, a.overflow);
      end
      tick;
      tests_run++;
      if (a.busy !== 1'b0) begin
         tests_failed++; $display("FAIL full_range_idle: got busy=%b expected 0", a.busy);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset_n = 1'b1;
      a.start = 1'b0; a.abort = 1'b0; a.mode = 1'b0; a.n_lo = '0; a.n_hi = '0;
      b.start = 1'b0; b.abort = 1'b0; b.mode = 1'b0; b.n_lo = '0; b.n_hi = '0;
      test_reset;
      test_sum_i;
      test_sum_sq;
      test_empty_single;
      test_overflow;
      test_abort;
      test_start_ignored;
      test_back_to_back;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
